// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RISC-V core: sequences fetch/decode/execute/
// memory/writeback and drives datapath enables, mux selects and the 2-bit aluop.
module multicycle_main_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       pc_src,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    LD_WB    = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BR       = 4'd8,
    FAULT    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam bit               TIMEOUT_EN = (MEM_WAIT_MAX != 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_fault_q, mem_fault_d;
  logic               waiting;
  logic               timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FETCH;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // A ready memory in the same cycle as the counter limit wins over the timeout.
  always_comb begin
    state_d = state_q;
    waiting = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    timeout = TIMEOUT_EN && waiting && !mem_ready && (wait_cnt_q == WAIT_MAX);

    case (state_q)
      FETCH: begin
        if (mem_ready)    state_d = DECODE;
        else if (timeout) state_d = FAULT;
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_RTYPE:          state_d = R_EXEC;
          OP_BRANCH:         state_d = BR;
          default:           state_d = FETCH;
        endcase
      end
      MEM_ADDR: state_d = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)    state_d = LD_WB;
        else if (timeout) state_d = FAULT;
      end
      LD_WB: state_d = FETCH;
      MEM_WR: begin
        if (mem_ready)    state_d = FETCH;
        else if (timeout) state_d = FAULT;
      end
      R_EXEC:  state_d = R_WB;
      R_WB:    state_d = FETCH;
      BR:      state_d = FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (waiting && !mem_ready && (wait_cnt_q != CNT_SAT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    mem_fault_d = mem_fault_q || (state_d == FAULT);
  end

  // Moore decode; everything is forced low while reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    pc_src     = 1'b0;
    illegal_op = 1'b0;
    mem_fault  = mem_fault_q;
    state_dbg  = state_q;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !((opcode == OP_LOAD) || (opcode == OP_STORE) ||
                       (opcode == OP_RTYPE) || (opcode == OP_BRANCH));
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
      end
      R_WB: reg_write = 1'b1;
      BR: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase

    if (!rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      aluop      = 2'b00;
      pc_src     = 1'b0;
      illegal_op = 1'b0;
      mem_fault  = 1'b0;
      state_dbg  = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle expected outputs are
// built from the state table, queued at drive time and compared mid-cycle.
module tb_multicycle_main_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_LD_WB = 4,
                 S_MEM_WR = 5, S_R_EXEC = 6, S_R_WB = 7, S_BR = 8, S_FAULT = 9;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b1111111;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       pc_src;
    logic       illegal_op;
    logic       mem_fault;
    logic [3:0] state_dbg;
  } outs_t;

  typedef struct {
    outs_t vec;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  outs_t      dut;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_WAIT_MAX(15), .CNT_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (dut.pc_write),
    .ir_write   (dut.ir_write),
    .i_or_d     (dut.i_or_d),
    .mem_read   (dut.mem_read),
    .mem_write  (dut.mem_write),
    .reg_write  (dut.reg_write),
    .mem_to_reg (dut.mem_to_reg),
    .alu_src_a  (dut.alu_src_a),
    .alu_src_b  (dut.alu_src_b),
    .aluop      (dut.aluop),
    .pc_src     (dut.pc_src),
    .illegal_op (dut.illegal_op),
    .mem_fault  (dut.mem_fault),
    .state_dbg  (dut.state_dbg)
  );

  function automatic outs_t model(int st, logic rst_n, logic [6:0] op, logic z, logic mr,
                                  logic flt);
    outs_t o;
    o = '0;
    if (!rst_n) return o;
    o.state_dbg = 4'(st);
    o.mem_fault = flt;
    case (st)
      S_FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      S_DECODE:   begin
        o.alu_src_b  = 2'b11;
        o.illegal_op = (op != OP_LD) && (op != OP_ST) && (op != OP_R) && (op != OP_BR);
      end
      S_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      S_MEM_RD:   begin o.mem_read = 1; o.i_or_d = 1; end
      S_LD_WB:    begin o.reg_write = 1; o.mem_to_reg = 1; end
      S_MEM_WR:   begin o.mem_write = 1; o.i_or_d = 1; end
      S_R_EXEC:   begin o.alu_src_a = 1; o.aluop = 2'b10; end
      S_R_WB:     o.reg_write = 1;
      S_BR:       begin o.alu_src_a = 1; o.aluop = 2'b01; o.pc_src = 1; o.pc_write = z; end
      default:    ;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs the spec requires for it.
  task automatic applyStimulus(input string tag, input logic rst_n, input logic [6:0] op,
                               input logic z, input logic mr, input int st, input logic flt);
    exp_t e;
    rst       = rst_n;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    e.vec = model(st, rst_n, op, z, mr, flt);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = sb_q.pop_front();
      assert (dut === e.vec) else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, dut, e.vec);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic rst_n, input logic [6:0] op,
                      input logic z, input logic mr, input int st, input logic flt);
    applyStimulus(tag, rst_n, op, z, mr, st, flt);
    checkOutput();
  endtask

  initial begin
    rst = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset0", 0, OP_R, 0, 1, S_FETCH, 0);
    step("reset1", 0, OP_R, 0, 1, S_FETCH, 0);

    step("r_fetch",  1, OP_R, 0, 1, S_FETCH,  0);
    step("r_decode", 1, OP_R, 0, 0, S_DECODE, 0);
    step("r_exec",   1, OP_R, 0, 0, S_R_EXEC, 0);
    step("r_wb",     1, OP_R, 0, 0, S_R_WB,   0);

    step("ld_fetch", 1, OP_LD, 0, 1, S_FETCH,    0);
    step("ld_dec",   1, OP_LD, 0, 0, S_DECODE,   0);
    step("ld_addr",  1, OP_LD, 0, 0, S_MEM_ADDR, 0);
    for (int i = 0; i < 3; i++) step("ld_wait", 1, OP_LD, 0, 0, S_MEM_RD, 0);
    step("ld_rd",    1, OP_LD, 0, 1, S_MEM_RD, 0);
    step("ld_wb",    1, OP_LD, 0, 0, S_LD_WB,  0);

    step("b1_fetch", 1, OP_BR, 1, 1, S_FETCH,  0);
    step("b1_dec",   1, OP_BR, 1, 0, S_DECODE, 0);
    step("b1_taken", 1, OP_BR, 1, 0, S_BR,     0);
    step("b0_fetch", 1, OP_BR, 0, 1, S_FETCH,  0);
    step("b0_dec",   1, OP_BR, 0, 0, S_DECODE, 0);
    step("b0_not",   1, OP_BR, 0, 0, S_BR,     0);

    step("st_fetch", 1, OP_ST, 0, 1, S_FETCH,    0);
    step("st_dec",   1, OP_ST, 0, 0, S_DECODE,   0);
    step("st_addr",  1, OP_ST, 0, 0, S_MEM_ADDR, 0);
    step("st_wait",  1, OP_ST, 0, 0, S_MEM_WR,   0);
    step("st_wait",  1, OP_ST, 0, 0, S_MEM_WR,   0);
    step("st_wr",    1, OP_ST, 0, 1, S_MEM_WR,   0);

    step("ill_fetch", 1, OP_ILL, 0, 1, S_FETCH,  0);
    step("ill_dec",   1, OP_ILL, 0, 0, S_DECODE, 0);

    for (int i = 0; i < 15; i++) step("to_wait", 1, OP_R, 0, 0, S_FETCH, 0);
    step("to_ready16", 1, OP_R, 0, 1, S_FETCH,  0);
    step("to_decode",  1, OP_R, 0, 0, S_DECODE, 0);
    step("to_exec",    1, OP_R, 0, 0, S_R_EXEC, 0);
    step("to_wb",      1, OP_R, 0, 0, S_R_WB,   0);

    step("rs_fetch", 1, OP_ST, 0, 1, S_FETCH,    0);
    step("rs_dec",   1, OP_ST, 0, 0, S_DECODE,   0);
    step("rs_addr",  1, OP_ST, 0, 0, S_MEM_ADDR, 0);
    step("rs_wait",  1, OP_ST, 0, 0, S_MEM_WR,   0);
    step("rs_wait",  1, OP_ST, 0, 0, S_MEM_WR,   0);
    step("rs_reset", 0, OP_ST, 0, 0, S_FETCH,    0);

    for (int i = 0; i < 16; i++) step("flt_wait", 1, OP_R, 0, 0, S_FETCH, 0);
    step("flt_enter",  1, OP_R, 0, 0, S_FAULT, 1);
    step("flt_sticky", 1, OP_R, 0, 1, S_FAULT, 1);
    step("flt_sticky", 1, OP_R, 1, 1, S_FAULT, 1);
    step("flt_reset",  0, OP_R, 0, 0, S_FETCH, 0);
    step("flt_clear",  1, OP_R, 0, 0, S_FETCH, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle variant of the RISC-V core.
- It is the producer of the 2-bit aluop that the ALU-control decoder consumes. Encoding: 00 = add, 01 = subtract/compare, 10 = use funct fields.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives datapath enables and muxes.
- Handshakes with a shared instruction/data memory via mem_ready, with a wait-state timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles a memory state may wait for mem_ready; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- opcode  input  7  instruction[6:0] from the instruction register; stable outside FETCH.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  PC load enable.
- ir_write  output  1  instruction-register load enable.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register-file write enable.
- mem_to_reg  output  1  writeback select: 1 = MDR, 0 = ALUOut.
- alu_src_a  output  1  ALU A: 0 = PC, 1 = rs1.
- alu_src_b  output  2  ALU B: 00 = rs2, 01 = constant 4, 10 = immediate, 11 = branch immediate.
- aluop  output  2  to ALU control: 00 add, 01 subtract, 10 funct-decoded.
- pc_src  output  1  PC source: 0 = ALU result, 1 = ALUOut.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- mem_fault  output  1  sticky memory-timeout flag.
- state_dbg  output  4  current state encoding.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LD_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BR=8, FAULT=9.
- Outputs are Moore-decoded from the state register. Exceptions: pc_write in FETCH and BR, ir_write, and illegal_op also depend on inputs as listed.
- Reset: while rst=0 at a clock edge, state goes to FETCH and the wait counter and mem_fault clear. All outputs read 0 while rst is low. First active state after release is FETCH.
- Reset mid-operation aborts the current instruction; no memory or register write occurs on that edge.
- Any output not listed in a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, aluop=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> R_EXEC; 1100011 -> BR.
  - Any other opcode -> FETCH with illegal_op=1 for this cycle only.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=00. Load goes to MEM_RD, store goes to MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to LD_WB.
- LD_WB: reg_write=1, mem_to_reg=1, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready, then goes to FETCH. mem_write stays high for the whole wait.
- R_EXEC: alu_src_a=1, alu_src_b=00, aluop=10, then R_WB.
- R_WB: reg_write=1, mem_to_reg=0, then FETCH.
- BR: alu_src_a=1, alu_src_b=00, aluop=01, pc_src=1, pc_write=zero, then FETCH.
- Total latency: R-type 4 cycles, load 5, store 4, branch 3, illegal 2, each plus memory wait cycles.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states while mem_ready=0.
  - If the counter equals MEM_WAIT_MAX and mem_ready=0 (and MEM_WAIT_MAX≠0), next state is FAULT.
  - mem_ready=1 in that same cycle wins and the normal transition is taken.
  - The counter saturates and never wraps.
- FAULT: all datapath outputs are 0 and mem_fault=1. The only exit is reset.

Test Plan:
- R-type: rst low 2 cycles, then opcode=0110011, mem_ready=1 -> states 0,1,6,7,0. aluop=10 only in R_EXEC; reg_write=1 only in R_WB; pc_write=1 only in the FETCH cycle.
- Load with 3 wait states: opcode=0000011, mem_ready low for 3 cycles in MEM_RD -> mem_read stays 1 for 4 cycles. LD_WB asserts reg_write=1 and mem_to_reg=1. Total 8 cycles.
- Branch: opcode=1100011 with zero=1 -> pc_write=1, pc_src=1, aluop=01 in BR. Repeat with zero=0 -> pc_write=0 in BR.
- Illegal: opcode=1111111 -> illegal_op=1 for exactly one DECODE cycle, back in FETCH next cycle, no reg_write or mem_write.
- Timeout: MEM_WAIT_MAX=15, mem_ready held low in FETCH -> FAULT after 16 cycles, mem_fault sticky. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no fault.
- Reset mid-store: rst=0 during a MEM_WR wait -> next cycle all outputs 0. After release, state=FETCH and mem_fault=0.
